// File: rtl/calc_controller_pkg.sv
// Shared definitions for the calculator controller: keypad codes, ALU ops, FSM states.
package calc_controller_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQU = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_OP_WAIT = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // Keypad code classification helpers
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_oper(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys are contiguous and in the same order as the ALU op codes
  function automatic alu_op_e key_to_op(input logic [3:0] k);
    return alu_op_e'(2'(k - KEY_ADD));
  endfunction

endpackage

// File: rtl/calc_controller_if.sv
// Start/done handshake between the calculator controller and the arithmetic unit.
interface calc_controller_if #(
  parameter int unsigned WIDTH = 16
);
  import calc_controller_pkg::*;

  logic             alu_start;
  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  modport master (
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_done, alu_result, alu_err
  );

  modport slave (
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_done, alu_result, alu_err
  );
endinterface

// File: rtl/calc_controller_key_sync.sv
// Keypad strobe synchronizer with rising-edge detect; one event per press.
module calc_controller_key_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_press,
  output logic       key_valid_c,
  output logic [3:0] key_code_q
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  // Synchronizer chain; code is latched as the strobe leaves the first flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      key_code_q <= 4'd0;
    end else begin
      sync1_q <= key_press;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (sync1_q && !sync2_q) begin
        key_code_q <= key_code;
      end
    end
  end

  // Edge detect on the settled stage only
  always_comb begin
    key_valid_c = sync2_q && !sync3_q;
  end

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencing FSM: assembles operands/operator and drives the ALU handshake.
module calc_controller
  import calc_controller_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_code,
  input  logic              key_press,
  calc_controller_if.master alu,
  output logic [WIDTH-1:0]  disp_value,
  output logic              disp_err,
  output logic              busy,
  output logic              key_drop
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  logic             key_valid_c;
  logic [3:0]       key_evt;
  logic [WIDTH-1:0] digit_val;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_e          op_q, op_d;
  alu_op_e          next_op_q, next_op_d;
  logic             chain_q, chain_d;
  logic             clr_pend_q, clr_pend_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic             clr_now;

  logic             start_d;
  alu_op_e          alu_op_d;
  logic [WIDTH-1:0] alu_a_d;
  logic [WIDTH-1:0] alu_b_d;
  logic [WIDTH-1:0] disp_d;
  logic             disp_err_d;
  logic             busy_d;
  logic             drop_d;

  calc_controller_key_sync u_key_sync (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .key_press  (key_press),
    .key_valid_c(key_valid_c),
    .key_code_q (key_evt)
  );

  assign digit_val = WIDTH'(key_evt);

  // State, operand and registered output storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ENTER_A;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= OP_ADD;
      next_op_q      <= OP_ADD;
      chain_q        <= 1'b0;
      clr_pend_q     <= 1'b0;
      cnt_a_q        <= '0;
      cnt_b_q        <= '0;
      alu.alu_start  <= 1'b0;
      alu.alu_op     <= OP_ADD;
      alu.alu_a      <= '0;
      alu.alu_b      <= '0;
      disp_value     <= '0;
      disp_err       <= 1'b0;
      busy           <= 1'b0;
      key_drop       <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      next_op_q      <= next_op_d;
      chain_q        <= chain_d;
      clr_pend_q     <= clr_pend_d;
      cnt_a_q        <= cnt_a_d;
      cnt_b_q        <= cnt_b_d;
      alu.alu_start  <= start_d;
      alu.alu_op     <= alu_op_d;
      alu.alu_a      <= alu_a_d;
      alu.alu_b      <= alu_b_d;
      disp_value     <= disp_d;
      disp_err       <= disp_err_d;
      busy           <= busy_d;
      key_drop       <= drop_d;
    end
  end

  // Completion first, then the key event against the post-completion state
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    next_op_d  = next_op_q;
    chain_d    = chain_q;
    clr_pend_d = clr_pend_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    clr_now    = 1'b0;
    start_d    = 1'b0;
    alu_op_d   = alu.alu_op;
    alu_a_d    = alu.alu_a;
    alu_b_d    = alu.alu_b;
    drop_d     = 1'b0;
    disp_d     = disp_value;

    if ((state_q == ST_EXEC) && alu.alu_done) begin
      chain_d    = 1'b0;
      clr_pend_d = 1'b0;
      if (clr_pend_q) begin
        clr_now = 1'b1;
      end else if (alu.alu_err) begin
        state_d = ST_ERROR;
      end else begin
        a_d = alu.alu_result;
        if (chain_q) begin
          op_d    = next_op_q;
          state_d = ST_OP_WAIT;
        end else begin
          state_d = ST_RESULT;
        end
      end
    end

    if (key_valid_c) begin
      if (key_evt == KEY_CLR) begin
        if (state_d == ST_EXEC) begin
          clr_pend_d = 1'b1;
        end else begin
          clr_now = 1'b1;
        end
      end else begin
        unique case (state_d)
          ST_ENTER_A: begin
            if (is_digit(key_evt)) begin
              if (cnt_a_d < CNT_W'(MAX_DIGITS)) begin
                a_d     = a_d * WIDTH'(10) + digit_val;
                cnt_a_d = cnt_a_d + CNT_W'(1);
              end else begin
                drop_d = 1'b1;
              end
            end else if (is_oper(key_evt)) begin
              op_d    = key_to_op(key_evt);
              state_d = ST_OP_WAIT;
            end
          end
          ST_OP_WAIT: begin
            if (is_digit(key_evt)) begin
              b_d     = digit_val;
              cnt_b_d = CNT_W'(1);
              state_d = ST_ENTER_B;
            end else if (is_oper(key_evt)) begin
              op_d = key_to_op(key_evt);
            end
          end
          ST_ENTER_B: begin
            if (is_digit(key_evt)) begin
              if (cnt_b_d < CNT_W'(MAX_DIGITS)) begin
                b_d     = b_d * WIDTH'(10) + digit_val;
                cnt_b_d = cnt_b_d + CNT_W'(1);
              end else begin
                drop_d = 1'b1;
              end
            end else begin
              start_d  = 1'b1;
              alu_op_d = op_d;
              alu_a_d  = a_d;
              alu_b_d  = b_d;
              state_d  = ST_EXEC;
              chain_d  = is_oper(key_evt);
              if (is_oper(key_evt)) begin
                next_op_d = key_to_op(key_evt);
              end
            end
          end
          ST_RESULT: begin
            if (is_digit(key_evt)) begin
              a_d     = digit_val;
              cnt_a_d = CNT_W'(1);
              state_d = ST_ENTER_A;
            end else if (is_oper(key_evt)) begin
              op_d    = key_to_op(key_evt);
              state_d = ST_OP_WAIT;
            end
          end
          ST_EXEC, ST_ERROR: begin
            drop_d = 1'b1;
          end
          default: begin
            state_d = ST_ENTER_A;
          end
        endcase
      end
    end

    if (clr_now) begin
      state_d    = ST_ENTER_A;
      a_d        = '0;
      b_d        = '0;
      op_d       = OP_ADD;
      next_op_d  = OP_ADD;
      chain_d    = 1'b0;
      clr_pend_d = 1'b0;
      cnt_a_d    = '0;
      cnt_b_d    = '0;
    end

    // Display follows the operand in view; EXEC and ERROR hold the last value
    if (clr_now) begin
      disp_d = '0;
    end else begin
      case (state_q)
        ST_ENTER_A, ST_OP_WAIT, ST_RESULT: disp_d = a_q;
        ST_ENTER_B:                        disp_d = b_q;
        default:                           disp_d = disp_value;
      endcase
    end

    busy_d     = (state_d == ST_EXEC);
    disp_err_d = (state_d == ST_ERROR);
  end

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: directed scenarios plus random keys against a calculator model.
module tb_calc_controller;
  import calc_controller_pkg::*;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } start_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       key_code = 4'd0;
  logic             key_press = 1'b0;
  logic [WIDTH-1:0] disp_value;
  logic             disp_err;
  logic             busy;
  logic             key_drop;

  calc_controller_if #(.WIDTH(WIDTH)) alu_if ();

  calc_controller #(.WIDTH(WIDTH), .MAX_DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_press (key_press),
    .alu       (alu_if),
    .disp_value(disp_value),
    .disp_err  (disp_err),
    .busy      (busy),
    .key_drop  (key_drop)
  );

  always #5 clk = ~clk;

  // Arithmetic unit behaviour (two's complement, WIDTH-bit wrap, div-by-zero error)
  function automatic logic [WIDTH-1:0] calc_res(input int op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    int sa, sb, res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      0: res = sa + sb;
      1: res = sa - sb;
      2: res = sa * sb;
      default: res = (sb == 0) ? 0 : sa / sb;
    endcase
    return WIDTH'(res);
  endfunction

  function automatic logic calc_err(input int op, input logic [WIDTH-1:0] b);
    return (op == 3) && (b == '0);
  endfunction

  // Stub ALU: done is seen by the controller 'lat' cycles after it raised alu_start
  int               lat = 3;
  int               st_left = 0;
  logic [WIDTH-1:0] pend_res = '0;
  logic             pend_err = 1'b0;

  always @(posedge clk) begin
    alu_if.alu_done <= 1'b0;
    if (rst) begin
      st_left           <= 0;
      alu_if.alu_result <= '0;
      alu_if.alu_err    <= 1'b0;
    end else if (alu_if.alu_start) begin
      pend_res <= calc_res(int'(alu_if.alu_op), alu_if.alu_a, alu_if.alu_b);
      pend_err <= calc_err(int'(alu_if.alu_op), alu_if.alu_b);
      st_left  <= lat - 2;
    end else if (st_left != 0) begin
      st_left <= st_left - 1;
      if (st_left == 1) begin
        alu_if.alu_done   <= 1'b1;
        alu_if.alu_result <= pend_res;
        alu_if.alu_err    <= pend_err;
      end
    end
  end

  // Event monitors sampled on the inactive edge
  int     n_start = 0;
  int     n_drop  = 0;
  int     n_busy  = 0;
  int     n_seven = 0;
  start_t recs[$];

  always @(negedge clk) begin
    if (alu_if.alu_start === 1'b1) begin
      n_start <= n_start + 1;
      recs.push_back({alu_if.alu_op, alu_if.alu_a, alu_if.alu_b});
    end
    if (key_drop === 1'b1) n_drop <= n_drop + 1;
    if (busy === 1'b1) n_busy <= n_busy + 1;
    if (disp_value === WIDTH'(7)) n_seven <= n_seven + 1;
  end

  function automatic start_t get_start(input int idx);
    if (idx < recs.size()) return recs[idx];
    return '1;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic press_raw(input logic [3:0] k);
    @(negedge clk);
    key_code  = k;
    key_press = 1'b1;
    repeat (3) @(negedge clk);
    key_press = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic press(input logic [3:0] k);
    press_raw(k);
    wait_idle("press");
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Calculator model: mode 0 first operand, 1 operator chosen, 2 second operand,
  // 3 result shown, 4 error
  int               m_mode, m_nd, m_op;
  logic [WIDTH-1:0] m_a, m_b, m_disp;
  logic             m_err;

  task automatic model_reset();
    m_mode = 0; m_nd = 0; m_op = 0;
    m_a = '0; m_b = '0; m_disp = '0; m_err = 1'b0;
  endtask

  task automatic model_key(input logic [3:0] k, output int drop, output int start,
                           output int sop, output logic [WIDTH-1:0] sa,
                           output logic [WIDTH-1:0] sb);
    drop = 0; start = 0; sop = 0; sa = '0; sb = '0;
    if (k == KEY_CLR) begin
      model_reset();
    end else if (m_mode == 4) begin
      drop = 1;
    end else if (k <= 4'd9) begin
      if (m_mode == 0 || m_mode == 2) begin
        if (m_nd < 4) begin
          if (m_mode == 0) m_a = WIDTH'(m_a * 10 + k);
          else             m_b = WIDTH'(m_b * 10 + k);
          m_nd++;
        end else begin
          drop = 1;
        end
      end else if (m_mode == 1) begin
        m_b = WIDTH'(k); m_nd = 1; m_mode = 2;
      end else begin
        m_a = WIDTH'(k); m_nd = 1; m_mode = 0;
      end
    end else if (m_mode == 2) begin
      start = 1; sop = m_op; sa = m_a; sb = m_b;
      if (calc_err(m_op, m_b)) begin
        m_mode = 4;
      end else begin
        m_a = calc_res(m_op, m_a, m_b);
        if (k == KEY_EQU) m_mode = 3;
        else begin m_op = int'(k) - 10; m_mode = 1; end
      end
    end else if (k != KEY_EQU) begin
      m_op = int'(k) - 10;
      m_mode = 1;
    end
    m_err = (m_mode == 4);
    if (m_mode == 2) m_disp = m_b;
    else if (m_mode != 4) m_disp = m_a;
  endtask

  initial begin
    int     s0, d0, b0, c7;
    start_t st;
    int     e_drop, e_start, e_op;
    logic [WIDTH-1:0] e_a, e_b;
    logic [3:0] k;
    int r;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset disp_value", 32'(disp_value), 32'd0);
    check("reset disp_err", {31'd0, disp_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset key_drop", {31'd0, key_drop}, 32'd0);
    check("reset alu_start", {31'd0, alu_if.alu_start}, 32'd0);

    // 12 + 34
    s0 = n_start;
    press(4'd1); press(4'd2);
    check("d1 entry A", 32'(disp_value), 32'd12);
    press(KEY_ADD);
    check("d1 op_wait shows A", 32'(disp_value), 32'd12);
    press(4'd3); press(4'd4);
    check("d1 entry B", 32'(disp_value), 32'd34);
    b0 = n_busy;
    press(KEY_EQU);
    check("d1 start count", 32'(n_start - s0), 32'd1);
    st = get_start(s0);
    check("d1 op", 32'(st.op), 32'd0);
    check("d1 a", 32'(st.a), 32'd12);
    check("d1 b", 32'(st.b), 32'd34);
    check("d1 busy cycles", 32'(n_busy - b0), 32'd3);
    check("d1 result", 32'(disp_value), 32'd46);
    check("d1 err", {31'd0, disp_err}, 32'd0);

    // 5 - 9 is negative
    press(KEY_CLR);
    press(4'd5); press(KEY_SUB); press(4'd9); press(KEY_EQU);
    check("d2 negative", 32'(disp_value), 32'h0000FFFC);

    // digit limit
    press(KEY_CLR);
    d0 = n_drop;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("d3 limited", 32'(disp_value), 32'd1234);
    check("d3 drops", 32'(n_drop - d0), 32'd1);
    press(KEY_ADD); press(4'd1); press(KEY_EQU);
    check("d3 sum", 32'(disp_value), 32'd1235);
    check("d3 drops after", 32'(n_drop - d0), 32'd1);

    // divide by zero and recovery
    press(KEY_CLR);
    press(4'd8); press(KEY_DIV); press(4'd0); press(KEY_EQU);
    check("d4 err", {31'd0, disp_err}, 32'd1);
    d0 = n_drop;
    press(4'd7);
    check("d4 drop in error", 32'(n_drop - d0), 32'd1);
    check("d4 disp held", 32'(disp_value), 32'd0);
    check("d4 err held", {31'd0, disp_err}, 32'd1);
    press(KEY_CLR);
    check("d4 clr disp", 32'(disp_value), 32'd0);
    check("d4 clr err", {31'd0, disp_err}, 32'd0);
    press(4'd3);
    check("d4 entry after clr", 32'(disp_value), 32'd3);

    // chained operator, key dropped during EXEC
    press(KEY_CLR);
    lat = 20;
    s0 = n_start;
    press(4'd2); press(KEY_MUL); press(4'd3);
    d0 = n_drop;
    press_raw(KEY_ADD);
    press_raw(4'd9);
    check("d5 busy during exec", {31'd0, busy}, 32'd1);
    wait_idle("d5");
    repeat (2) @(negedge clk);
    check("d5 drop in exec", 32'(n_drop - d0), 32'd1);
    check("d5 chained shows result", 32'(disp_value), 32'd6);
    lat = 3;
    press(4'd4);
    check("d5 entry B", 32'(disp_value), 32'd4);
    press(KEY_EQU);
    check("d5 start count", 32'(n_start - s0), 32'd2);
    st = get_start(s0);
    check("d5 first op", 32'(st.op), 32'd2);
    check("d5 first a", 32'(st.a), 32'd2);
    check("d5 first b", 32'(st.b), 32'd3);
    st = get_start(s0 + 1);
    check("d5 second op", 32'(st.op), 32'd0);
    check("d5 second a", 32'(st.a), 32'd6);
    check("d5 second b", 32'(st.b), 32'd4);
    check("d5 result", 32'(disp_value), 32'd10);

    // CLR while the operation is outstanding
    press(KEY_CLR);
    lat = 20;
    press(4'd6); press(KEY_ADD); press(4'd1);
    c7 = n_seven;
    press_raw(KEY_EQU);
    press_raw(KEY_CLR);
    check("d6 busy held", {31'd0, busy}, 32'd1);
    wait_idle("d6");
    repeat (2) @(negedge clk);
    check("d6 disp cleared", 32'(disp_value), 32'd0);
    check("d6 err", {31'd0, disp_err}, 32'd0);
    check("d6 result never shown", 32'(n_seven - c7), 32'd0);
    lat = 3;
    press(4'd2);
    check("d6 entry after clr", 32'(disp_value), 32'd2);

    // reset mid-entry
    press(KEY_CLR);
    press(4'd4); press(4'd5);
    check("d7 entry", 32'(disp_value), 32'd45);
    do_reset();
    check("d7 rst disp", 32'(disp_value), 32'd0);
    check("d7 rst err", {31'd0, disp_err}, 32'd0);
    check("d7 rst busy", {31'd0, busy}, 32'd0);
    check("d7 rst drop", {31'd0, key_drop}, 32'd0);
    check("d7 rst start", {31'd0, alu_if.alu_start}, 32'd0);
    press(4'd3);
    check("d7 digit after rst", 32'(disp_value), 32'd3);

    // random keys against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 80) k = 4'(10 + $urandom_range(0, 3));
      else if (r < 93) k = KEY_EQU;
      else             k = KEY_CLR;
      lat = int'($urandom_range(3, 6));
      s0 = n_start;
      d0 = n_drop;
      model_key(k, e_drop, e_start, e_op, e_a, e_b);
      press(k);
      check("rnd disp", 32'(disp_value), 32'(m_disp));
      check("rnd err", {31'd0, disp_err}, {31'd0, m_err});
      check("rnd drop", 32'(n_drop - d0), 32'(e_drop));
      check("rnd starts", 32'(n_start - s0), 32'(e_start));
      if (e_start == 1) begin
        st = get_start(s0);
        check("rnd start op", 32'(st.op), 32'(e_op));
        check("rnd start a", 32'(st.a), 32'(e_a));
        check("rnd start b", 32'(st.b), 32'(e_b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Sequencing FSM for the calculator. Consumes keypad events (key_code/key_press) and assembles decimal operands and the operator.
- Issues one operation at a time to the arithmetic unit over a start/done handshake and drives the display value and error flag.
- Sits between the keypad and the arithmetic unit; single clock domain.

Parameters:
WIDTH, 16, operand/result width, two's complement
MAX_DIGITS, 4, max decimal digits accepted per operand; 10^MAX_DIGITS-1 must fit in WIDTH-1 bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key_code  in  4  keypad code: 0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQU, 15 CLR
key_press  in  1  keypad strobe, asynchronous to clk; key_code is stable before it rises
alu_start  out  1  one-cycle request to arithmetic unit
alu_op  out  2  0 ADD, 1 SUB, 2 MUL, 3 DIV; valid with alu_start
alu_a  out  WIDTH  left operand; held stable from alu_start until alu_done
alu_b  out  WIDTH  right operand; held stable from alu_start until alu_done
alu_done  in  1  one-cycle completion pulse; arrives at least 1 cycle after alu_start
alu_result  in  WIDTH  result, valid with alu_done
alu_err  in  1  divide-by-zero/overflow, valid with alu_done
disp_value  out  WIDTH  signed value to display
disp_err  out  1  error indicator
busy  out  1  high while an operation is outstanding
key_drop  out  1  one-cycle pulse when a key event is discarded

Behaviour:
- Reset: all outputs 0. State ENTER_A, A=B=0, op=ADD, digit counters 0, clr_pend=0. Any outstanding operation is abandoned; a later alu_done is ignored.
- Key capture: key_press goes through a 2-flop synchronizer plus rising-edge detect. key_code is captured on the detected edge, giving exactly one event per press.
  - Event latency: press first sampled high at edge k; event acts at edge k+2; disp_value updates at edge k+3.
- Digit entry: operand = operand*10 + digit, computed in WIDTH bits.
  - Digits beyond MAX_DIGITS are discarded and pulse key_drop.
  - disp_value shows the operand currently being entered.
- States:
  - ENTER_A:
    - digit -> accumulate into A
    - operator -> latch op, go OP_WAIT
    - EQU -> no change
  - OP_WAIT:
    - digit -> B=digit, go ENTER_B
    - operator -> replace op
    - EQU -> ignored, no key_drop
    - disp_value keeps showing A
  - ENTER_B:
    - digit -> accumulate into B
    - EQU or operator -> pulse alu_start with A/B/op, set busy, go EXEC
    - If the trigger was an operator, record it as next_op with chain=1.
  - EXEC: wait for alu_done.
    - alu_err=1 -> ERROR, disp_err=1.
    - Otherwise A=alu_result, disp_value=alu_result, busy=0. Then chain=1 -> op=next_op, go OP_WAIT; chain=0 -> go RESULT.
    - Non-CLR keys in EXEC are dropped with key_drop.
  - RESULT:
    - digit -> A=digit, go ENTER_A
    - operator -> latch op, go OP_WAIT (chaining on the result)
    - EQU -> no change
  - ERROR: every key except CLR is dropped with key_drop; disp_err stays 1.
- CLR: from any state except EXEC, clears A, B, op, counters, disp_value and disp_err, and goes to ENTER_A in the event cycle.
- CLR during EXEC: sets clr_pend. On alu_done the result/err is discarded and the CLR action is applied. busy stays high until then.
- Simultaneous events: an alu_done and a key event in the same cycle are both processed; the key is evaluated against the post-done state. alu_start is never reasserted while busy=1.
- Operands entered are non-negative. SUB may produce negative results, shown as two's complement.

Decomposition:
- Shared header calc_defs.vh holds:
  - keypad code defines (ADD..CLR, same values as keypad input)
  - ALU op encodings
  - FSM state encodings (ENTER_A, OP_WAIT, ENTER_B, EXEC, RESULT, ERROR)
- Sub-module key_sync: 2-flop synchronizer and rising-edge detector. Outputs a 1-cycle key_valid and the registered key_code.

Test Plan:
- Stub ALU, 3-cycle latency. Reset, keys 1,2,+,3,4,EQU -> one alu_start with op=0, a=12, b=34; busy high 3 cycles; disp_value=46, disp_err=0.
- Keys 5,-,9,EQU -> disp_value=16'hFFFC (-4).
- Keys 1,2,3,4,5 -> disp_value=1234, one key_drop pulse; then +,1,EQU -> 1235.
- Keys 8,/,0,EQU with stub alu_err=1 -> disp_err=1; key 7 -> key_drop, no change; CLR -> disp_value=0, disp_err=0, state ENTER_A.
- Keys 2,*,3,+,4,EQU -> alu_start twice: (op2, 2, 3), then (op0, 6, 4); disp_value=10. Key 9 during first EXEC -> key_drop, result unaffected.
- Keys 6,+,1,EQU then CLR before alu_done -> result 7 never displayed, disp_value=0 after done. rst asserted after keys 4,5 -> all outputs 0, next digit 3 shows 3.
